uart_rx: RTL

//  Serial receiver for the host UART link: the receive side of the 8N1 link

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and frame data width.
// The transmitter imports the same package.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Both flops load RESET_VAL in reset so the output is a known level straight away.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling from a down-counting bit timer, one-cycle
// valid / framing-error pulses and a running mod-2^32 sum of good bytes.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | line idle high, waiting for a falling edge
//  START     | timing to the middle of the start bit, re-checking it is low
//  DATA      | sampling 8 data bits LSB first, one per bit period
//  STOP      | timing to the middle of the stop bit
//  WAIT_HIGH | framing error seen; waiting for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_serial,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_frame_err,
    output logic [31:0] o_sum
);

    localparam int TW = $clog2(clocks_per_bit);
    localparam logic [TW-1:0] T_HALF = TW'(clocks_per_bit / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(clocks_per_bit - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      w_line_s;
    rx_state_t                 r_state;
    logic [TW-1:0]             r_timer;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_valid;
    logic [7:0]                r_data;
    logic                      r_frame_err;
    logic [31:0]               r_sum;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_serial),
        .o_q   (w_line_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_frame_err <= 1'b0;
            r_sum       <= '0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_line_s) begin
                        r_state <= START;
                        r_timer <= T_HALF;
                    end
                end
                START: begin
                    if (r_timer == '0) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (w_line_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                            r_timer   <= T_FULL;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                DATA: begin
                    if (r_timer == '0) begin
                        r_shift <= {w_line_s, r_shift[UART_DATA_BITS-1:1]};
                        r_timer <= T_FULL;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                STOP: begin
                    if (r_timer == '0) begin
                        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                        if (w_line_s) begin
                            r_valid <= 1'b1;
                            r_data  <= r_shift;
                            r_sum   <= r_sum + {24'd0, r_shift};
                            r_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_HIGH;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (w_line_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_frame_err = r_frame_err;
    assign o_sum       = r_sum;

endmodule
